// File: rtl/adma_pkg.sv
// Shared definitions for the ADMA write-response path: AXI B response
// codes, the per-channel transfer state encoding and a response
// classification helper.
package adma_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_DRAIN  = 2'b10
  } adma_chn_state_e;

  // A write response is an error only for SLVERR and DECERR.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic v_err;
    case (resp)
      RESP_SLVERR, RESP_DECERR: v_err = 1'b1;
      RESP_OKAY, RESP_EXOKAY:   v_err = 1'b0;
      default:                  v_err = 1'b0;
    endcase
    return v_err;
  endfunction

endpackage

// File: rtl/adma_wr_resp_chn.sv
// One destination channel of the write-response tracker: outstanding
// burst counter, IDLE/ACTIVE/DRAIN transfer FSM and sticky done/error
// status. Build option ADMA_BRESP_ID_CHK_EN additionally flags a B beat
// whose BID differs from the channel's expected ID as an error.
module adma_wr_resp_chn
  import adma_pkg::*;
#(
  parameter int MST_ID_W     = 5,
  parameter int TRANS_RESP_W = 2,
  parameter int OUTST_CNT_W  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_burst_issue,
  output logic                    o_issue_ready,
  input  logic                    i_xfer_end,
  input  logic [MST_ID_W-1:0]     i_chn_id,
  input  logic [MST_ID_W-1:0]     i_bid,
  input  logic [TRANS_RESP_W-1:0] i_bresp,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  input  logic                    i_sts_clr,
  output logic                    o_done_sts,
  output logic                    o_err_sts,
  output logic                    o_chn_busy
);

  localparam logic [OUTST_CNT_W-1:0] CNT_ZERO = {OUTST_CNT_W{1'b0}};
  localparam logic [OUTST_CNT_W-1:0] CNT_MAX  = {OUTST_CNT_W{1'b1}};
  localparam logic [OUTST_CNT_W-1:0] CNT_ONE  = {{(OUTST_CNT_W-1){1'b0}}, 1'b1};

  adma_chn_state_e        r_state;
  logic [OUTST_CNT_W-1:0] r_cnt;
  logic [OUTST_CNT_W-1:0] w_cnt_nxt;
  logic                   r_done_sts;
  logic                   r_err_sts;
  logic                   w_bready;
  logic                   w_bhs;
  logic                   w_issue_ready;
  logic                   w_issue;
  logic                   w_id_err;
  logic                   w_err;
  logic                   w_done;

  // A B beat can only be accepted while a burst is outstanding, so a
  // stray response after reset or before any issue is held off.
  assign w_bready = (r_cnt != CNT_ZERO);
  assign w_bhs    = i_bvalid & w_bready;

  // At saturation a retiring B beat frees the slot in the same cycle.
  assign w_issue_ready = ~((r_cnt == CNT_MAX) & ~w_bhs);
  assign w_issue       = i_burst_issue & w_issue_ready;

`ifdef ADMA_BRESP_ID_CHK_EN
  assign w_id_err = (i_bid != i_chn_id);
`else
  logic w_unused_id;
  assign w_unused_id = ^{i_bid, i_chn_id};
  assign w_id_err    = 1'b0;
`endif

  assign w_err = w_bhs & (resp_is_err(i_bresp[1:0]) | w_id_err);

  // Next outstanding count: issue and retire in one cycle cancel out.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_issue & ~w_bhs) begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end else if (~w_issue & w_bhs) begin
      w_cnt_nxt = r_cnt - CNT_ONE;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Transfer completion: zero-burst end in IDLE, end coinciding with the
  // last response in ACTIVE, or the last response arriving in DRAIN.
  always_comb begin
    w_done = 1'b0;
    case (r_state)
      ST_IDLE:   w_done = i_xfer_end & ~w_issue;
      ST_ACTIVE: w_done = i_xfer_end & (w_cnt_nxt == CNT_ZERO);
      ST_DRAIN:  w_done = (w_cnt_nxt == CNT_ZERO);
      default:   w_done = 1'b0;
    endcase
  end

  // Counter, transfer FSM and sticky status (a set beats a same-cycle clear).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= CNT_ZERO;
      r_state    <= ST_IDLE;
      r_done_sts <= 1'b0;
      r_err_sts  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state <= i_xfer_end ? ST_DRAIN : ST_ACTIVE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (i_xfer_end) begin
            r_state <= (w_cnt_nxt == CNT_ZERO) ? ST_IDLE : ST_DRAIN;
          end else begin
            r_state <= ST_ACTIVE;
          end
        end
        ST_DRAIN: begin
          if (w_cnt_nxt == CNT_ZERO) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_DRAIN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_done) begin
        r_done_sts <= 1'b1;
      end else if (i_sts_clr) begin
        r_done_sts <= 1'b0;
      end else begin
        r_done_sts <= r_done_sts;
      end
      if (w_err) begin
        r_err_sts <= 1'b1;
      end else if (i_sts_clr) begin
        r_err_sts <= 1'b0;
      end else begin
        r_err_sts <= r_err_sts;
      end
    end
  end

  assign o_bready      = w_bready;
  assign o_issue_ready = w_issue_ready;
  assign o_done_sts    = r_done_sts;
  assign o_err_sts     = r_err_sts;
  assign o_chn_busy    = (r_state != ST_IDLE);

endmodule

// File: rtl/adma_wr_resp.sv
// ADMA write-response collector: one adma_wr_resp_chn per destination
// channel plus the registered, masked interrupt reduction.
// Build option: ADMA_BRESP_ID_CHK_EN enables BID checking in each channel.
module adma_wr_resp
  import adma_pkg::*;
#(
  parameter int DST_CHANNEL_NUM = 4,
  parameter int MST_ID_W        = 5,
  parameter int TRANS_RESP_W    = 2,
  parameter int OUTST_CNT_W     = 4
) (
  input  logic                                      aclk,
  input  logic                                      areset,
  input  logic [DST_CHANNEL_NUM-1:0]                burst_issue_i,
  output logic [DST_CHANNEL_NUM-1:0]                issue_ready_o,
  input  logic [DST_CHANNEL_NUM-1:0]                xfer_end_i,
  input  logic [DST_CHANNEL_NUM-1:0][MST_ID_W-1:0]  chn_id_i,
  input  logic [MST_ID_W-1:0]                       m_bid_i    [0:DST_CHANNEL_NUM-1],
  input  logic [TRANS_RESP_W-1:0]                   m_bresp_i  [0:DST_CHANNEL_NUM-1],
  input  logic                                      m_bvalid_i [0:DST_CHANNEL_NUM-1],
  output logic                                      m_bready_o [0:DST_CHANNEL_NUM-1],
  input  logic [DST_CHANNEL_NUM-1:0]                done_mask_i,
  input  logic [DST_CHANNEL_NUM-1:0]                err_mask_i,
  input  logic [DST_CHANNEL_NUM-1:0]                sts_clr_i,
  output logic [DST_CHANNEL_NUM-1:0]                done_sts_o,
  output logic [DST_CHANNEL_NUM-1:0]                err_sts_o,
  output logic [DST_CHANNEL_NUM-1:0]                chn_busy_o,
  output logic                                      irq
);

  logic [DST_CHANNEL_NUM-1:0] w_done_sts;
  logic [DST_CHANNEL_NUM-1:0] w_err_sts;
  logic [DST_CHANNEL_NUM-1:0] w_issue_ready;
  logic [DST_CHANNEL_NUM-1:0] w_busy;
  logic                       r_irq;

  for (genvar c = 0; c < DST_CHANNEL_NUM; c++) begin : g_chn
    adma_wr_resp_chn #(
      .MST_ID_W     (MST_ID_W),
      .TRANS_RESP_W (TRANS_RESP_W),
      .OUTST_CNT_W  (OUTST_CNT_W)
    ) u_chn (
      .i_clk         (aclk),
      .i_rst         (areset),
      .i_burst_issue (burst_issue_i[c]),
      .o_issue_ready (w_issue_ready[c]),
      .i_xfer_end    (xfer_end_i[c]),
      .i_chn_id      (chn_id_i[c]),
      .i_bid         (m_bid_i[c]),
      .i_bresp       (m_bresp_i[c]),
      .i_bvalid      (m_bvalid_i[c]),
      .o_bready      (m_bready_o[c]),
      .i_sts_clr     (sts_clr_i[c]),
      .o_done_sts    (w_done_sts[c]),
      .o_err_sts     (w_err_sts[c]),
      .o_chn_busy    (w_busy[c])
    );
  end

  // Interrupt: any unmasked sticky done or error status, registered.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |((w_done_sts & done_mask_i) | (w_err_sts & err_mask_i));
    end
  end

  assign issue_ready_o = w_issue_ready;
  assign done_sts_o    = w_done_sts;
  assign err_sts_o     = w_err_sts;
  assign chn_busy_o    = w_busy;
  assign irq           = r_irq;

endmodule

// File: tb/tb_adma_wr_resp.sv
// Self-checking bench for adma_wr_resp: a vector table applied cycle by
// cycle with registered expectations queued as each vector is driven,
// followed by hand-written saturation and mid-transfer reset sequences.
module tb_adma_wr_resp;

  logic       aclk = 1'b0;
  logic       areset;
  logic [3:0] burst_issue_i, issue_ready_o, xfer_end_i;
  logic [3:0][4:0] chn_id_i;
  logic [4:0] m_bid_i    [0:3];
  logic [1:0] m_bresp_i  [0:3];
  logic       m_bvalid_i [0:3];
  logic       m_bready_o [0:3];
  logic [3:0] done_mask_i, err_mask_i, sts_clr_i;
  logic [3:0] done_sts_o, err_sts_o, chn_busy_o;
  logic       irq;

  adma_wr_resp dut (
    .aclk          (aclk),
    .areset        (areset),
    .burst_issue_i (burst_issue_i),
    .issue_ready_o (issue_ready_o),
    .xfer_end_i    (xfer_end_i),
    .chn_id_i      (chn_id_i),
    .m_bid_i       (m_bid_i),
    .m_bresp_i     (m_bresp_i),
    .m_bvalid_i    (m_bvalid_i),
    .m_bready_o    (m_bready_o),
    .done_mask_i   (done_mask_i),
    .err_mask_i    (err_mask_i),
    .sts_clr_i     (sts_clr_i),
    .done_sts_o    (done_sts_o),
    .err_sts_o     (err_sts_o),
    .chn_busy_o    (chn_busy_o),
    .irq           (irq)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [3:0] iss, xend, bval;
    logic [7:0] bresp;
    logic [3:0] clr;
    logic [3:0] x_bready, x_iready;
    logic [3:0] x_done, x_err, x_busy;
    logic       x_irq;
  } vec_t;

  typedef struct {
    logic [3:0] done, err, busy;
    logic       irq;
  } exp_t;

  localparam int NV = 17;
  vec_t tbl [0:NV-1];
  exp_t sb_q [$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic logic [3:0] bready_vec();
    return {m_bready_o[3], m_bready_o[2], m_bready_o[1], m_bready_o[0]};
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] iss, input logic [3:0] xend, input logic [3:0] bval,
                       input logic [7:0] bresp, input logic [3:0] clr);
    burst_issue_i = iss;
    xfer_end_i    = xend;
    sts_clr_i     = clr;
    for (int c = 0; c < 4; c++) begin
      m_bvalid_i[c] = bval[c];
      m_bresp_i[c]  = bresp[2*c +: 2];
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_bready"}, bready_vec(), 4'b0000);
    chk({tag, "_iready"}, issue_ready_o, 4'b1111);
    chk({tag, "_busy"}, chn_busy_o, 4'b0000);
    chk({tag, "_done"}, done_sts_o, 4'b0000);
    chk({tag, "_err"}, err_sts_o, 4'b0000);
    chk({tag, "_irq"}, {3'b000, irq}, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] id_err_exp;
    exp_t       e;
    int         nb;

`ifdef ADMA_BRESP_ID_CHK_EN
    id_err_exp = 4'b0010;
`else
    id_err_exp = 4'b0000;
`endif
    //          iss      xend     bval     bresp   clr      bready   iready   done     err         busy     irq
    tbl[0]  = '{4'b0001, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000,   4'b0001, 1'b0};
    tbl[1]  = '{4'b0001, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0001, 4'b1111, 4'b0000, 4'b0000,   4'b0001, 1'b0};
    tbl[2]  = '{4'b0001, 4'b0001, 4'b0000, 8'h00, 4'b0000, 4'b0001, 4'b1111, 4'b0000, 4'b0000,   4'b0001, 1'b0};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0001, 8'h00, 4'b0000, 4'b0001, 4'b1111, 4'b0000, 4'b0000,   4'b0001, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0001, 8'h00, 4'b0000, 4'b0001, 4'b1111, 4'b0000, 4'b0000,   4'b0001, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0001, 8'h00, 4'b0000, 4'b0001, 4'b1111, 4'b0001, 4'b0000,   4'b0000, 1'b0};
    tbl[6]  = '{4'b0000, 4'b0000, 4'b0001, 8'h03, 4'b0000, 4'b0000, 4'b1111, 4'b0001, 4'b0000,   4'b0000, 1'b1};
    tbl[7]  = '{4'b0000, 4'b1000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b1111, 4'b1001, 4'b0000,   4'b0000, 1'b1};
    tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0001, 4'b0000, 4'b1111, 4'b1000, 4'b0000,   4'b0000, 1'b1};
    tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b1111, 4'b1000, 4'b0000,   4'b0000, 1'b0};
    tbl[10] = '{4'b0100, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b1111, 4'b1000, 4'b0000,   4'b0100, 1'b0};
    tbl[11] = '{4'b0100, 4'b0000, 4'b0100, 8'h20, 4'b0000, 4'b0100, 4'b1111, 4'b1000, 4'b0100,   4'b0100, 1'b0};
    tbl[12] = '{4'b0100, 4'b0100, 4'b0100, 8'h30, 4'b0100, 4'b0100, 4'b1111, 4'b1000, 4'b0100,   4'b0100, 1'b1};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0100, 8'h10, 4'b0100, 4'b0100, 4'b1111, 4'b1100, 4'b0000,   4'b0000, 1'b1};
    tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b1100, 4'b0000, 4'b1111, 4'b0000, 4'b0000,   4'b0000, 1'b0};
    tbl[15] = '{4'b0010, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000,   4'b0010, 1'b0};
    tbl[16] = '{4'b0000, 4'b0010, 4'b0010, 8'h00, 4'b0000, 4'b0010, 4'b1111, 4'b0010, id_err_exp, 4'b0000, 1'b0};

    // Static configuration: ch1 expects ID 03 but the slave answers 04.
    chn_id_i[0] = 5'h10;
    chn_id_i[1] = 5'h03;
    chn_id_i[2] = 5'h12;
    chn_id_i[3] = 5'h13;
    m_bid_i[0]  = 5'h10;
    m_bid_i[1]  = 5'h04;
    m_bid_i[2]  = 5'h12;
    m_bid_i[3]  = 5'h13;
    done_mask_i = 4'b0001;
    err_mask_i  = 4'b0100;
    drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);

    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
    chk_reset_state("por");

    // Table-driven main sequence.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].iss, tbl[i].xend, tbl[i].bval, tbl[i].bresp, tbl[i].clr);
      #1;
      chk($sformatf("v%0d_bready", i), bready_vec(), tbl[i].x_bready);
      chk($sformatf("v%0d_iready", i), issue_ready_o, tbl[i].x_iready);
      sb_q.push_back('{tbl[i].x_done, tbl[i].x_err, tbl[i].x_busy, tbl[i].x_irq});
      step();
      e = sb_q.pop_front();
      chk($sformatf("v%0d_done", i), done_sts_o, e.done);
      chk($sformatf("v%0d_err", i), err_sts_o, e.err);
      chk($sformatf("v%0d_busy", i), chn_busy_o, e.busy);
      chk($sformatf("v%0d_irq", i), {3'b000, irq}, {3'b000, e.irq});
    end

    // Saturation on ch1: 15 issues fill the counter.
    done_mask_i = 4'b0010;
    drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b1111);
    step();
    for (int k = 0; k < 15; k++) begin
      drive(4'b0010, 4'b0000, 4'b0000, 8'h00, 4'b0000);
      step();
    end
    drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);
    #1;
    chk("sat_iready_low", issue_ready_o, 4'b1101);
    chk("sat_busy", chn_busy_o, 4'b0010);
    // Issue while not ready must be dropped.
    drive(4'b0010, 4'b0000, 4'b0000, 8'h00, 4'b0000);
    step();
    // Issue together with a retiring B: accepted, count stays at max.
    drive(4'b0010, 4'b0000, 4'b0010, 8'h00, 4'b0000);
    #1;
    chk("sat_iready_hs", issue_ready_o, 4'b1111);
    step();
    drive(4'b0000, 4'b0010, 4'b0000, 8'h00, 4'b0000);
    #1;
    chk("sat_iready_after", issue_ready_o, 4'b1101);
    step();
    // Drain: exactly 15 responses must be accepted.
    drive(4'b0000, 4'b0000, 4'b0010, 8'h00, 4'b0000);
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      if (m_bready_o[1]) begin
        nb++;
        step();
      end else begin
        break;
      end
    end
    n_chk++;
    if (nb != 15) begin
      n_err++;
      $display("FAIL sat_drain_count: got %0d expected 15", nb);
    end
    chk("sat_done", done_sts_o, 4'b0010);
    chk("sat_busy_end", chn_busy_o, 4'b0000);
    drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);
    step();
    chk("sat_irq", {3'b000, irq}, 4'b0001);

    // Mid-transfer reset on ch0 with 5 bursts outstanding in DRAIN.
    for (int k = 0; k < 5; k++) begin
      drive(4'b0001, (k == 4) ? 4'b0001 : 4'b0000, 4'b0000, 8'h00, 4'b0000);
      step();
    end
    drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);
    #1;
    chk("pre_rst_busy", chn_busy_o, 4'b0001);
    chk("pre_rst_bready", bready_vec(), 4'b0001);
    areset = 1'b1;
    step();
    areset = 1'b0;
    chk_reset_state("rst");
    drive(4'b0000, 4'b0000, 4'b0001, 8'h02, 4'b0000);
    #1;
    chk("post_rst_bready", bready_vec(), 4'b0000);
    step();
    chk("post_rst_err", err_sts_o, 4'b0000);
    chk("post_rst_busy", chn_busy_o, 4'b0000);
    drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/adma_wr_resp.md
ADMA_WR_RESP -- requirements
Module: adma_wr_resp

Interface
REQ-001 SHALL have parameter DST_CHANNEL_NUM, default 4, number of destination write channels.
REQ-002 SHALL have parameter MST_ID_W, default 5, AXI ID width.
REQ-003 SHALL have parameter TRANS_RESP_W, default 2, AXI response width.
REQ-004 SHALL have parameter OUTST_CNT_W, default 4, per-channel outstanding-burst counter width (max 2^OUTST_CNT_W-1).
REQ-005 SHALL have port aclk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have port areset  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port burst_issue_i  input  [DST_CHANNEL_NUM]  pulse per AW handshake completed by the write host.
REQ-008 SHALL have port issue_ready_o  output  [DST_CHANNEL_NUM]  channel may accept another AW issue.
REQ-009 SHALL have port xfer_end_i  input  [DST_CHANNEL_NUM]  pulse: final burst of current transfer issued (may coincide with burst_issue_i).
REQ-010 SHALL have port chn_id_i  input  MST_ID_W x DST_CHANNEL_NUM  expected BID per channel.
REQ-011 SHALL have ports m_bid_i, m_bresp_i, m_bvalid_i (inputs), m_bready_o (output), unpacked [0:DST_CHANNEL_NUM-1], AXI4 B channel per destination.
REQ-012 SHALL have ports done_mask_i, err_mask_i, sts_clr_i  input  [DST_CHANNEL_NUM]  irq masks and write-1-to-clear from register map.
REQ-013 SHALL have ports done_sts_o, err_sts_o  output  [DST_CHANNEL_NUM]  sticky status; chn_busy_o  output  [DST_CHANNEL_NUM]; irq  output  1.

Function
REQ-014 SHALL keep per channel an outstanding counter: +1 on burst_issue_i, -1 on B handshake (bvalid&bready), unchanged when both occur in the same cycle.
REQ-015 SHALL drive issue_ready_o[c] low when counter equals max and no B handshake this cycle; burst_issue_i while issue_ready_o low is ignored.
REQ-016 SHALL drive m_bready_o[c] = (counter != 0) combinationally; a B beat with counter 0 is never accepted.
REQ-017 SHALL run per-channel FSM IDLE -> ACTIVE on first burst_issue_i; ACTIVE -> DRAIN on xfer_end_i; DRAIN -> IDLE when counter reaches 0 (including the cycle xfer_end_i and last B coincide).
REQ-018 SHALL, on DRAIN -> IDLE, pulse internal done and set done_sts_o[c] on the next edge (1-cycle latency after final B handshake).
REQ-019 SHALL set err_sts_o[c] on any B handshake with bresp in {SLVERR, DECERR}; EXOKAY and OKAY do not set it.
REQ-020 SHALL clear done_sts_o[c]/err_sts_o[c] on sts_clr_i[c]; simultaneous set and clear: set wins.
REQ-021 SHALL drive chn_busy_o[c] = (state != IDLE).
REQ-022 SHALL drive irq registered: OR over channels of (done_sts & done_mask) | (err_sts & err_mask).
REQ-023 SHALL treat xfer_end_i in IDLE with no issue as zero-burst transfer: done_sts set next cycle.

Reset
REQ-024 SHALL on areset: counters 0, FSMs IDLE, done_sts_o/err_sts_o 0, irq 0, m_bready_o 0, issue_ready_o 1, chn_busy_o 0.
REQ-025 SHALL, on areset mid-transfer, discard outstanding count; subsequent B beats are not accepted until new issues.

Configuration
REQ-026 SHALL support macro ADMA_BRESP_ID_CHK_EN: when defined, a B handshake with m_bid_i[c] != chn_id_i[c] sets err_sts_o[c] and still decrements; when undefined, m_bid_i is ignored.

Structure
REQ-027 SHALL take response codes (OKAY 00, EXOKAY 01, SLVERR 10, DECERR 11) and FSM state enum from shared package adma_pkg.
REQ-028 SHALL instantiate one sub-module adma_wr_resp_chn per channel (counter, FSM, status); top holds irq reduction only.

Verification
REQ-029 SHALL test: ch0 issues 3 bursts, xfer_end with 3rd, 3 OKAY B beats -> done_sts_o[0]=1 one cycle after 3rd B, chn_busy_o[0]=0, irq=1 with done_mask[0]=1.
REQ-030 SHALL test: OUTST_CNT_W=4, 15 issues no B -> issue_ready_o=0; same-cycle issue+B -> counter stays 15, issue accepted.
REQ-031 SHALL test: ch2 B with bresp=2'b10 -> err_sts_o[2]=1; sts_clr_i[2] same cycle as a new error -> err_sts_o[2] stays 1.
REQ-032 SHALL test: areset asserted with counter=5 in DRAIN -> all outputs at reset values next cycle, m_bready_o=0.
REQ-033 SHALL test: with ADMA_BRESP_ID_CHK_EN, chn_id_i[1]=5'h03, m_bid_i[1]=5'h04 OKAY -> err_sts_o[1]=1; without macro -> err_sts_o[1]=0.
REQ-034 SHALL test: xfer_end_i[3] in IDLE, no issues -> done_sts_o[3]=1 next cycle, masked irq stays 0 when done_mask[3]=0.
